if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the LC-3b pipeline. It sits directly upstream of the IF/ID latch and drives that latch's IR_in, PC_in, load_latch and inject_NOP inputs.
- Owns the fetch PC and the instruction-memory read handshake.
- Holds fetched words while the hazard unit stalls.
- Handles branch/jump redirects from later stages, including redirects that arrive while a memory read is still outstanding.

---
 rtl/lc3b_types.sv | 19 +
 rtl/register.sv | 18 +
 rtl/if_fetch_stage.sv | 136 +++++++++++++
 tb/tb_if_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch stage: machine word and fetch FSM states.
package lc3b_types;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } lc3b_fetch_state;

  // Instruction addresses are halfword aligned; bit 0 is dropped.
  function automatic lc3b_word align_word(input lc3b_word addr);
    return {addr[WORD_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/register.sv
// Loadable register with asynchronous active-low reset to a fixed value.
module register #(
  parameter int unsigned     WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// LC-3b instruction-fetch stage feeding the IF/ID latch.
// Optional perf counters (fetch_count, bubble_count) under IF_FETCH_PERF_CNT_EN.
module if_fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     stall_in,
  input  logic     redirect_valid,
  input  lc3b_word redirect_pc,
  output logic     imem_read,
  output lc3b_word imem_address,
  input  logic     imem_resp,
  input  lc3b_word imem_rdata,
  output lc3b_word ir_out,
  output lc3b_word pc_out,
  output logic     load_latch,
  output logic     inject_nop
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
`endif
);

  lc3b_fetch_state state, state_next;
  lc3b_word        pc, pc_next, pc_plus2, buffer, pending, target;
  lc3b_word        deliver_word;
  logic            pc_load, buffer_load, pending_load;
  logic            read_req, deliver, deliver_g;

  assign pc_plus2 = pc + 16'd2;
  assign target   = align_word(redirect_pc);

  register #(.WIDTH(WORD_W), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset_n(reset_n), .load(pc_load), .d(pc_next), .q(pc)
  );

  register #(.WIDTH(WORD_W), .RESET_VAL('0)) u_buffer (
    .clk(clk), .reset_n(reset_n), .load(buffer_load), .d(imem_rdata), .q(buffer)
  );

  register #(.WIDTH(WORD_W), .RESET_VAL('0)) u_pending (
    .clk(clk), .reset_n(reset_n), .load(pending_load), .d(target), .q(pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  // Next state, register loads and delivery decision; redirect beats stall.
  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    pc_next      = pc_plus2;
    buffer_load  = 1'b0;
    pending_load = 1'b0;
    read_req     = 1'b0;
    deliver      = 1'b0;
    deliver_word = '0;
    case (state)
      FETCH: begin
        read_req = 1'b1;
        if (redirect_valid) begin
          if (imem_resp) begin
            pc_load = 1'b1;
            pc_next = target;
          end else begin
            pending_load = 1'b1;
            state_next   = SQUASH;
          end
        end else if (imem_resp) begin
          if (stall_in) begin
            buffer_load = 1'b1;
            state_next  = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            pc_load      = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_load    = 1'b1;
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall_in) begin
          deliver      = 1'b1;
          deliver_word = buffer;
          pc_load      = 1'b1;
          state_next   = FETCH;
        end
      end
      SQUASH: begin
        // The stale read must complete before the new target can be fetched.
        read_req = 1'b1;
        if (imem_resp) begin
          pc_load    = 1'b1;
          pc_next    = redirect_valid ? target : pending;
          state_next = FETCH;
        end else if (redirect_valid) begin
          pending_load = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign deliver_g    = reset_n & deliver;
  assign load_latch   = reset_n & (~stall_in | redirect_valid);
  assign inject_nop   = load_latch & ~deliver_g;
  assign imem_read    = reset_n & read_req;
  assign imem_address = reset_n ? pc : '0;
  assign ir_out       = deliver_g ? deliver_word : '0;
  assign pc_out       = deliver_g ? pc_plus2 : '0;

`ifdef IF_FETCH_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (deliver_g && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (inject_nop && !redirect_valid && bubble_count != 16'hFFFF)
        bubble_count <= bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        load_latch;
  logic        inject_nop;

  int passes = 0;
  int checks = 0;

  // Reference model: where fetch stands, plus any parked word or redirect target.
  logic [15:0] m_pc;
  logic        m_holding;
  logic [15:0] m_held;
  logic        m_squashing;
  logic [15:0] m_target;

  int wcnt = 0;
  int lat  = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .ir_out(ir_out), .pc_out(pc_out),
    .load_latch(load_latch), .inject_nop(inject_nop)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_holding = 1'b0; m_held = '0;
    m_squashing = 1'b0; m_target = '0;
    wcnt = 0; lat = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".read"}, {15'b0, imem_read}, 16'h0);
    check_eq({tag, ".addr"}, imem_address, 16'h0);
    check_eq({tag, ".ir"}, ir_out, 16'h0);
    check_eq({tag, ".pc"}, pc_out, 16'h0);
    check_eq({tag, ".load"}, {15'b0, load_latch}, 16'h0);
    check_eq({tag, ".nop"}, {15'b0, inject_nop}, 16'h0);
  endtask

  // Drive one cycle's inputs (caller is at a negedge) and compare against the model.
  task automatic apply(input logic s, input logic rv, input logic [15:0] rp,
                       input logic rs, input logic [15:0] rd);
    logic dlv, ld;
    logic [15:0] word;
    stall_in = s; redirect_valid = rv; redirect_pc = rp;
    imem_resp = rs; imem_rdata = rd;
    #2;
    dlv  = !m_squashing && !rv && !s && (m_holding || rs);
    word = m_holding ? m_held : rd;
    ld   = !s || rv;
    check_eq("read", {15'b0, imem_read}, {15'b0, !m_holding});
    check_eq("addr", imem_address, m_pc);
    check_eq("load", {15'b0, load_latch}, {15'b0, ld});
    check_eq("nop", {15'b0, inject_nop}, {15'b0, ld && !dlv});
    check_eq("ir", ir_out, dlv ? word : 16'h0);
    check_eq("pc_out", pc_out, dlv ? m_pc + 16'd2 : 16'h0);
  endtask

  // Advance the model across the rising edge using the inputs currently driven.
  task automatic step();
    logic [15:0] tgt;
    @(posedge clk);
    tgt = {redirect_pc[15:1], 1'b0};
    if (m_holding) begin
      if (redirect_valid) begin m_pc = tgt; m_holding = 1'b0; end
      else if (!stall_in) begin m_pc = m_pc + 16'd2; m_holding = 1'b0; end
    end else if (m_squashing) begin
      if (redirect_valid) m_target = tgt;
      if (imem_resp) begin m_pc = m_target; m_squashing = 1'b0; end
    end else if (redirect_valid) begin
      if (imem_resp) m_pc = tgt;
      else begin m_squashing = 1'b1; m_target = tgt; end
    end else if (imem_resp) begin
      if (stall_in) begin m_holding = 1'b1; m_held = imem_rdata; end
      else m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    model_reset();
    #1;
    check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel.read", {15'b0, imem_read}, 16'h1);
    check_eq("rel.addr", imem_address, 16'h0000);
  endtask

  initial begin
    model_reset();

    // Reset release and two back-to-back 1-cycle responses.
    do_reset();
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'h1234);
    check_eq("d1.ir", ir_out, 16'h1234);
    check_eq("d1.pc", pc_out, 16'h0002);
    check_eq("d1.nop", {15'b0, inject_nop}, 16'h0);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'h5678);
    check_eq("d2.ir", ir_out, 16'h5678);
    check_eq("d2.pc", pc_out, 16'h0004);
    step();

    // Response during stall is held, then delivered.
    do_reset();
    @(negedge clk); apply(1, 0, 16'h0, 1, 16'hABCD);
    check_eq("st.load", {15'b0, load_latch}, 16'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); apply(1, 0, 16'h0, 0, 16'h0);
      check_eq("st.hold_read", {15'b0, imem_read}, 16'h0);
      check_eq("st.hold_load", {15'b0, load_latch}, 16'h0);
      step();
    end
    @(negedge clk); apply(0, 0, 16'h0, 0, 16'h0);
    check_eq("st.ir", ir_out, 16'hABCD);
    check_eq("st.pc", pc_out, 16'h0002);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 0, 16'h0);
    check_eq("st.next_addr", imem_address, 16'h0002);
    step();

    // Redirect while a 2-cycle read is outstanding.
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'h1111);
    step();
    @(negedge clk); apply(0, 1, 16'h0101, 0, 16'h0);
    check_eq("sq.addr", imem_address, 16'h0004);
    check_eq("sq.nop", {15'b0, inject_nop}, 16'h1);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'hDEAD);
    check_eq("sq.discard_nop", {15'b0, inject_nop}, 16'h1);
    check_eq("sq.discard_ir", ir_out, 16'h0);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 0, 16'h0);
    check_eq("sq.new_addr", imem_address, 16'h0100);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'hBEEF);
    check_eq("sq.first_pc", pc_out, 16'h0102);
    step();

    // Redirect, response and stall together.
    @(negedge clk); apply(1, 1, 16'h0200, 1, 16'h3333);
    check_eq("all.load", {15'b0, load_latch}, 16'h1);
    check_eq("all.nop", {15'b0, inject_nop}, 16'h1);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 0, 16'h0);
    check_eq("all.addr", imem_address, 16'h0200);
    step();

    // Asynchronous reset in the middle of an outstanding read.
    @(negedge clk); apply(0, 1, 16'h0040, 1, 16'h0);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 0, 16'h0);
    check_eq("ar.addr", imem_address, 16'h0040);
    #1 reset_n = 1'b0;
    #1 check_all_zero("ar.async");
    model_reset();
    @(negedge clk);
    imem_resp = 1'b1; imem_rdata = 16'hFFFF;
    #1 check_all_zero("ar.late");
    @(negedge clk);
    imem_resp = 1'b0; imem_rdata = '0;
    reset_n = 1'b1;
    #1;
    check_eq("ar.rel_read", {15'b0, imem_read}, 16'h1);
    check_eq("ar.rel_addr", imem_address, 16'h0000);
    step();
    @(negedge clk); apply(0, 0, 16'h0, 1, 16'h4242);
    check_eq("ar.first_pc", pc_out, 16'h0002);
    step();

    // Randomized traffic with variable memory latency.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic rs;
      @(negedge clk);
      rs = 1'b0;
      if (imem_read) begin
        if (wcnt == 0) lat = int'($urandom_range(0, 2));
        rs = (wcnt == lat);
        wcnt = rs ? 0 : wcnt + 1;
      end
      apply(($urandom % 4) == 0, ($urandom % 8) == 0, 16'($urandom), rs, 16'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
